// File: rtl/program_memory_loader_if.sv
// Byte-stream and program-memory write signals of the loader, grouped as one bundle.
// master = stream source / memory side; slave = the loader itself.
interface program_memory_loader_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  mem_write;
    logic [DATA_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready,
        input  mem_write,
        input  mem_address,
        input  mem_data
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready,
        output mem_write,
        output mem_address,
        output mem_data
    );
endinterface

// File: rtl/program_memory_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to program memory,
// holding the core in reset while loading. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module program_memory_loader #(
    parameter int unsigned MEMORY_DEPTH = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned BASE_ADDRESS = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Start_i,
    input  logic [COUNT_WIDTH-1:0] Word_Count_i,
    program_memory_loader_if.slave bus,
    output logic                   Busy_o,
    output logic                   Core_Hold_o,
    output logic                   Done_o,
    output logic                   Error_o
);

    // Words that fit between BASE_ADDRESS and the top of memory.
    localparam int unsigned Capacity =
        (BASE_ADDRESS >= MEMORY_DEPTH) ? 0 : MEMORY_DEPTH - BASE_ADDRESS;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone, StCheck} state_e;
`else
    typedef enum logic [2:0] {StIdle, StCollect, StWrite, StDone} state_e;
`endif

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [DATA_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_data_q, mem_data_d;
    logic                   mem_write_q, mem_write_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    logic        accept;
    logic [31:0] count_ext;
    state_e      after_last;

    assign accept    = ready_q & bus.byte_valid;
    assign count_ext = 32'(Word_Count_i);
`ifdef LOADER_CHECKSUM_EN
    assign after_last = StCheck;
`else
    assign after_last = StDone;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        error_d    = error_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif

        case (state_q)
            StIdle: begin
                if (Start_i) begin
                    count_d    = Word_Count_i;
                    idx_d      = '0;
                    byte_cnt_d = 2'd0;
                    error_d    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = 8'd0;
`endif
                    if (Word_Count_i == '0) begin
                        state_d = after_last;
                    end else if (count_ext > Capacity) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end

            StCollect: begin
                if (accept) begin
                    // Shift in from the top so the first byte ends up as the LSB.
                    data_d     = {bus.byte_data, data_q[DATA_WIDTH-1:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = sum_q + bus.byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = StWrite;
                        mem_addr_d = DATA_WIDTH'(BASE_ADDRESS) + DATA_WIDTH'(idx_q);
                        mem_data_d = data_d;
                    end
                end
            end

            StWrite: begin
                if (idx_q == count_q - COUNT_WIDTH'(1)) begin
                    state_d = after_last;
                end else begin
                    idx_d   = idx_q + COUNT_WIDTH'(1);
                    state_d = StCollect;
                end
            end

`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (accept) begin
                    if (bus.byte_data != sum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered, decoded from the state being entered.
        busy_d      = (state_d != StIdle);
        mem_write_d = (state_d == StWrite);
        done_d      = (state_d == StDone);
`ifdef LOADER_CHECKSUM_EN
        ready_d     = (state_d == StCollect) || (state_d == StCheck);
`else
        ready_d     = (state_d == StCollect);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= 2'd0;
            data_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            data_q      <= data_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.byte_ready  = ready_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_address = mem_addr_q;
    assign bus.mem_data    = mem_data_q;
    assign Busy_o          = busy_q;
    assign Core_Hold_o     = busy_q;
    assign Done_o          = done_q;
    assign Error_o         = error_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Scoreboarded bench for program_memory_loader: loads are described as byte lists, the expected
// writes and completion status are queued up front, and a negedge monitor checks what appears.
module tb_program_memory_loader;

    localparam int unsigned MemoryDepth = 32;
    localparam int unsigned BaseAddress = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word_count = '0;
    logic        busy, hold, done, error;

    program_memory_loader_if #(.DATA_WIDTH(32)) bus_if ();

    program_memory_loader #(
        .MEMORY_DEPTH(MemoryDepth),
        .DATA_WIDTH  (32),
        .COUNT_WIDTH (16),
        .BASE_ADDRESS(BaseAddress)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Start_i     (start),
        .Word_Count_i(word_count),
        .bus         (bus_if),
        .Busy_o      (busy),
        .Core_Hold_o (hold),
        .Done_o      (done),
        .Error_o     (error)
    );

    always #5 clk = ~clk;

    wr_t     exp_wr[$];
    logic    exp_done[$];
    wr_t     mon_e;
    logic    mon_de;
    int      n_pass = 0;
    int      n_total = 0;
    time     accept_time, done_time;
    bit      poke_start = 1'b0;
    byte_q_t bq;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every strobe and every Done pulse must match the queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            check("hold_eq_busy", {63'd0, hold}, {63'd0, busy});
            if (bus_if.mem_write) begin
                check("ready_low_in_write", {63'd0, bus_if.byte_ready}, 64'd0);
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("write_addr", {32'd0, bus_if.mem_address}, {32'd0, mon_e.addr});
                    check("write_data", {32'd0, bus_if.mem_data}, {32'd0, mon_e.data});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_de = exp_done.pop_front();
                    check("done_error", {63'd0, error}, {63'd0, mon_de});
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_flags"}, {58'd0, busy, hold, done, error, bus_if.byte_ready,
              bus_if.mem_write}, 64'd0);
        check({name, "_addr"}, {32'd0, bus_if.mem_address}, 64'd0);
        check({name, "_data"}, {32'd0, bus_if.mem_data}, 64'd0);
    endtask

    // All driving tasks start and end 1 time unit after a rising edge.
    task automatic start_load(input int count);
        start      = 1'b1;
        word_count = 16'(count);
        @(posedge clk);
        accept_time = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        bit r = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus_if.byte_valid = 1'b0;
            if (poke_start) begin
                start      = 1'b1;
                word_count = 16'd0;
            end
            @(negedge clk);
            check("hold_during_gap", {63'd0, hold}, 64'd1);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        bus_if.byte_data  = b;
        bus_if.byte_valid = 1'b1;
        do begin
            @(negedge clk);
            r = bus_if.byte_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 200);
        if (!r) check("byte_accept_timeout", 64'd0, 64'd1);
        bus_if.byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_time = $time;
            end
            n++;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Reference model: word i is bytes 4i..4i+3 little-endian at BaseAddress+i; checksum is the
    // byte sum mod 256 and a wrong one is reported as an error with Done.
    task automatic do_load(input byte_q_t b, input int gap_lo, input int gap_hi,
                           input int ck_delta);
        int          cnt = b.size() / 4;
        int unsigned sum = 0;
        int unsigned w;
        int unsigned ck;
        wr_t         e;
        for (int i = 0; i < cnt; i++) begin
            w = b[4*i] + 256 * b[4*i+1] + 65536 * b[4*i+2] + 16777216 * b[4*i+3];
            e.addr = BaseAddress + i;
            e.data = w;
            exp_wr.push_back(e);
        end
        foreach (b[i]) sum += b[i];
        ck = (sum + ck_delta) % 256;
`ifdef LOADER_CHECKSUM_EN
        exp_done.push_back(ck != sum % 256);
`else
        exp_done.push_back(1'b0);
`endif
        start_load(cnt);
        check("error_clear_on_start", {63'd0, error}, 64'd0);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        foreach (b[i]) send_byte(b[i], $urandom_range(gap_hi, gap_lo));
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'(ck), $urandom_range(gap_hi, gap_lo));
`endif
        wait_done(1000);
        check("idle_after_done", {63'd0, busy}, 64'd0);
    endtask

    task automatic rand_bytes(input int words);
        bq.delete();
        for (int i = 0; i < 4 * words; i++) bq.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        wr_t e;
        bus_if.byte_data  = 8'd0;
        bus_if.byte_valid = 1'b0;

        // Reset held for 3 cycles, then released.
        repeat (3) begin
            @(negedge clk);
            check_all_zero("in_reset");
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("after_reset");

        // Two-word load with valid always high, timing of Done checked.
        bq = {8'h93, 8'h02, 8'h50, 8'h00, 8'h13, 8'h03, 8'h10, 8'h00};
        do_load(bq, 0, 0, 0);
        // Done is the 11th cycle after the Start cycle (one more with the checksum byte).
`ifdef LOADER_CHECKSUM_EN
        check("done_latency", 64'(done_time - accept_time), 64'd115);
`else
        check("done_latency", 64'(done_time - accept_time), 64'd105);
`endif
        check("error_after_load", {63'd0, error}, 64'd0);

        // Same stream with 3-cycle gaps; Start pulses during gaps must be ignored.
        poke_start = 1'b1;
        do_load(bq, 3, 3, 0);
        poke_start = 1'b0;

        // Overflow: count one past capacity.
        start_load(MemoryDepth - BaseAddress + 1);
        check("overflow_error", {63'd0, error}, 64'd1);
        check("overflow_busy", {63'd0, busy}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("overflow_stays_idle", {62'd0, busy, error}, 64'd1);
        end
        @(posedge clk);
        #1;
        rand_bytes(1);
        do_load(bq, 0, 1, 0);

        // Zero-count load: no writes, Done only.
        bq.delete();
        do_load(bq, 0, 0, 0);

        // Reset after 2 bytes of word 1 in a 2-word load.
        bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        e.addr = BaseAddress;
        e.data = 32'h44332211;
        exp_wr.push_back(e);
        start_load(2);
        foreach (bq[i]) send_byte(bq[i], 0);
        reset = 1'b0;
        #1;
        check_all_zero("mid_load_reset");
        check("mid_load_writes_left", 64'(exp_wr.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        rand_bytes(2);
        do_load(bq, 0, 0, 0);

        // Randomised loads.
        for (int t = 0; t < 6; t++) begin
            rand_bytes($urandom_range(4, 1));
            do_load(bq, 0, 2, ($urandom_range(3, 0) == 0) ? $urandom_range(255, 1) : 0);
        end

        // Full memory: final address is MemoryDepth-1.
        rand_bytes(MemoryDepth - BaseAddress);
        do_load(bq, 0, 0, 0);

`ifdef LOADER_CHECKSUM_EN
        bq = {8'h01, 8'h02, 8'h03, 8'h04};
        do_load(bq, 0, 0, 0);
        check("checksum_good_error", {63'd0, error}, 64'd0);
        do_load(bq, 0, 0, 1);
        check("checksum_bad_sticky", {63'd0, error}, 64'd1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("writes_drained", 64'(exp_wr.size()), 64'd0);
        check("dones_drained", 64'(exp_done.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
